// File: rtl/common.sv
// Shared execute-path definitions: ALU operation codes, the ID/EX payload
// record and the skid-buffer occupancy states.
package common;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef struct packed {
        logic [2:0]  alu_control;
        logic [31:0] left_operand;
        logic [31:0] right_operand;
        logic [4:0]  rd;
        logic        reg_write;
    } id_ex_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline register built as a two-entry skid buffer. The main entry
// drives the execute stage; the skid entry catches the one payload that can
// arrive while execute stalls, so in_ready never depends on out_ready in the
// same cycle.
module id_ex_skid_stage
    import common::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_alu_control,
    input  logic [31:0] in_left_operand,
    input  logic [31:0] in_right_operand,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_alu_control,
    output logic [31:0] out_left_operand,
    output logic [31:0] out_right_operand,
    output logic [4:0]  out_rd,
    output logic        out_reg_write
);

    skid_state_t    state_q, state_d;
    id_ex_payload_t main_q, main_d;
    id_ex_payload_t skid_q, skid_d;
    id_ex_payload_t in_payload;
    logic           in_ready_q;
    logic           in_xfer;
    logic           out_xfer;

    assign in_payload = '{alu_control:   in_alu_control,
                          left_operand:  in_left_operand,
                          right_operand: in_right_operand,
                          rd:            in_rd,
                          reg_write:     in_reg_write};

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign in_xfer   = in_valid & in_ready_q;
    assign out_xfer  = out_valid & out_ready;

    // Next occupancy and payload movement; flush overrides every transfer.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch;
        // blocking '=' here, non-blocking '<=' only in the clocked block.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = ONE;
                    main_d  = in_payload;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_payload;
                end else if (in_xfer) begin
                    state_d = FULL;
                    skid_d  = in_payload;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so any offered input is ignored.
                if (out_xfer) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
    end

    // State and payload registers; in_ready is registered from next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: payload registers are reset too, so outputs read as zero
            // after reset rather than leftover data.
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    assign out_alu_control   = main_q.alu_control;
    assign out_left_operand  = main_q.left_operand;
    assign out_right_operand = main_q.right_operand;
    assign out_rd            = main_q.rd;
    // A drained entry keeps its data but must never look like a register write.
    assign out_reg_write     = main_q.reg_write & out_valid;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Self-checking bench for id_ex_skid_stage. The reference model is a bounded
// FIFO queue (capacity two) of accepted payloads: the head is what execute
// sees, and the stage is ready whenever fewer than two payloads are held.
module tb_id_ex_skid_stage;
    import common::*;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_alu_control;
    logic [31:0] in_left_operand;
    logic [31:0] in_right_operand;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_alu_control;
    logic [31:0] out_left_operand;
    logic [31:0] out_right_operand;
    logic [4:0]  out_rd;
    logic        out_reg_write;

    int checks = 0;
    int errors = 0;

    id_ex_payload_t mq[$];

    id_ex_skid_stage dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_alu_control    (in_alu_control),
        .in_left_operand   (in_left_operand),
        .in_right_operand  (in_right_operand),
        .in_rd             (in_rd),
        .in_reg_write      (in_reg_write),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_alu_control   (out_alu_control),
        .out_left_operand  (out_left_operand),
        .out_right_operand (out_right_operand),
        .out_rd            (out_rd),
        .out_reg_write     (out_reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic id_ex_payload_t mk(input logic [2:0] op, input logic [31:0] l,
                                          input logic [31:0] r, input logic [4:0] rd,
                                          input logic rw);
        id_ex_payload_t p;
        p.alu_control   = op;
        p.left_operand  = l;
        p.right_operand = r;
        p.rd            = rd;
        p.reg_write     = rw;
        return p;
    endfunction

    function automatic id_ex_payload_t dut_out();
        return mk(out_alu_control, out_left_operand, out_right_operand, out_rd, out_reg_write);
    endfunction

    task automatic drive(input logic v, input id_ex_payload_t p, input logic ordy,
                         input logic fl, input logic rn);
        in_valid         = v;
        in_alu_control   = p.alu_control;
        in_left_operand  = p.left_operand;
        in_right_operand = p.right_operand;
        in_rd            = p.rd;
        in_reg_write     = p.reg_write;
        out_ready        = ordy;
        flush            = fl;
        reset_n          = rn;
    endtask

    // One clock edge; the model applies the stage's rules at the same edge.
    task automatic tick();
        bit in_x;
        bit out_x;
        id_ex_payload_t p;
        p     = mk(in_alu_control, in_left_operand, in_right_operand, in_rd, in_reg_write);
        in_x  = in_valid && (mq.size() < 2);
        out_x = out_ready && (mq.size() > 0);
        @(posedge clk);
        if (!reset_n || flush) begin
            mq.delete();
        end else begin
            if (out_x) void'(mq.pop_front());
            if (in_x) mq.push_back(p);
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, mk(ALU_ADD, 32'd11, 32'd22, 5'd3, 1'b1), 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (dut_out() !== '0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", dut_out());
        end
    endtask

    task automatic test_streaming();
        id_ex_payload_t a, b;
        a = mk(ALU_ADD, 32'd5, 32'd3, 5'd1, 1'b1);
        b = mk(ALU_SUB, 32'd9, 32'd4, 5'd2, 1'b1);
        drive(1'b1, a, 1'b1, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || dut_out() !== a) begin
            errors++; $display("FAIL stream_add got v=%b %h want v=1 %h", out_valid, dut_out(), a);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL stream_ready1 got %b want 1", in_ready);
        end
        drive(1'b1, b, 1'b1, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || dut_out() !== b) begin
            errors++; $display("FAIL stream_sub got v=%b %h want v=1 %h", out_valid, dut_out(), b);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL stream_ready2 got %b want 1", in_ready);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin
            errors++; $display("FAIL stream_drain got v=%b rw=%b want v=0 rw=0", out_valid, out_reg_write);
        end
    endtask

    task automatic test_backpressure();
        id_ex_payload_t a, b, c;
        a = mk(ALU_AND, 32'hF0F0_0001, 32'h0FF0_1234, 5'd10, 1'b1);
        b = mk(ALU_OR,  32'h1234_5678, 32'h8765_4321, 5'd11, 1'b0);
        c = mk(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd31, 1'b1);
        drive(1'b1, a, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, b, 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (in_ready !== 1'b0 || dut_out() !== a) begin
            errors++; $display("FAIL bp_full got rdy=%b %h want rdy=0 %h", in_ready, dut_out(), a);
        end
        drive(1'b1, c, 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || dut_out() !== a) begin
            errors++; $display("FAIL bp_hold got rdy=%b v=%b %h want rdy=0 v=1 %h", in_ready, out_valid, dut_out(), a);
        end
        drive(1'b1, c, 1'b1, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || dut_out() !== b || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_second got v=%b rdy=%b %h want v=1 rdy=1 %h", out_valid, in_ready, dut_out(), b);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || dut_out() !== c) begin
            errors++; $display("FAIL bp_third got v=%b %h want v=1 %h", out_valid, dut_out(), c);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_empty got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, mk(ALU_ADD, 32'd1, 32'd2, 5'd4, 1'b1), 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, mk(ALU_SUB, 32'd3, 32'd4, 5'd5, 1'b1), 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_prefull got rdy=%b want 0", in_ready);
        end
        drive(1'b1, mk(ALU_OR, 32'd6, 32'd7, 5'd6, 1'b1), 1'b1, 1'b1, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_reg_write !== 1'b0 || out_rd !== 5'd0) begin
            errors++; $display("FAIL flush_clear got v=%b rdy=%b rw=%b rd=%0d want v=0 rdy=1 rw=0 rd=0",
                               out_valid, in_ready, out_reg_write, out_rd);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL flush_residue cycle %0d got v=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, mk(ALU_ADD, 32'd70, 32'd7, 5'd7, 1'b1), 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, mk(ALU_SUB, 32'd77, 32'd7, 5'd7, 1'b1), 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_rd !== 5'd7 || out_reg_write !== 1'b1) begin
            errors++; $display("FAIL rstmid_full got rdy=%b rd=%0d rw=%b want rdy=0 rd=7 rw=1",
                               in_ready, out_rd, out_reg_write);
        end
        drive(1'b1, mk(ALU_OR, 32'd1, 32'd1, 5'd9, 1'b1), 1'b1, 1'b1, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_reg_write !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_clear got v=%b rd=%0d rw=%b rdy=%b want v=0 rd=0 rw=0 rdy=1",
                               out_valid, out_rd, out_reg_write, in_ready);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_random();
        logic [2:0] ops [4];
        int shown = 0;
        int bad;
        id_ex_payload_t p, exp_p;
        ops[0] = ALU_AND; ops[1] = ALU_OR; ops[2] = ALU_ADD; ops[3] = ALU_SUB;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            p = mk(ops[$urandom_range(0, 3)], $urandom, $urandom,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            drive(($urandom_range(0, 9) < 6), p, ($urandom_range(0, 9) < 5),
                  ($urandom_range(0, 199) == 0), 1'b1);
            bad = 0;
            if (out_valid !== (mq.size() > 0)) bad = 1;
            if (in_ready !== (mq.size() < 2)) bad = 1;
            if (mq.size() > 0) begin
                exp_p = mq[0];
                if (dut_out() !== exp_p) bad = 1;
            end else if (out_reg_write !== 1'b0) begin
                bad = 1;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random cycle %0d got v=%b rdy=%b %h want held=%0d head=%h",
                             cyc, out_valid, in_ready, dut_out(), mq.size(),
                             (mq.size() > 0) ? mq[0] : id_ex_payload_t'('0));
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
